// File: rtl/nileswan_pkg.sv
// nileswan_pkg: shared constants for the nileswan cartridge mapper.
//   - I/O port addresses decoded from AddrLo[7:0]
//   - register reset values
//   - MBC_UNLOCK, the 16-bit mapper authentication word (sent LSB first)
//   - SPI shifter state encoding
package nileswan_pkg;

    localparam logic [7:0] PORT_BANK_LINEAR = 8'hC0;
    localparam logic [7:0] PORT_BANK_RAM    = 8'hC1;
    localparam logic [7:0] PORT_BANK_ROM0   = 8'hC2;
    localparam logic [7:0] PORT_BANK_ROM1   = 8'hC3;
    localparam logic [7:0] PORT_SPI_DATA    = 8'hE0;
    localparam logic [7:0] PORT_SPI_CTRL    = 8'hE1;
    localparam logic [7:0] PORT_LED         = 8'hE2;

    localparam logic [7:0] BANK_RESET     = 8'hFF;
    localparam logic [7:0] SPI_CTRL_RESET = 8'h02;
    localparam logic [7:0] SPI_DATA_RESET = 8'h00;
    localparam logic [7:0] LED_RESET      = 8'h00;

    localparam logic [15:0] MBC_UNLOCK = 16'h4A35;

    typedef enum logic {
        SPI_IDLE,
        SPI_XFER
    } spiState_t;

endpackage

// File: rtl/nileswan_spi.sv
// nileswan_spi: mode-0 SPI master byte shifter, MSB first.
// Ports:
//   clk, reset          - clock and synchronous active-high reset
//   start, txByte       - load txByte and begin a transfer (ignored while busy)
//   sdi                 - MISO, sampled on the rising sclk
//   busy                - high from the load edge until the final falling sclk
//   sclk, sdo           - SPI clock (idles 0) and MOSI (0 while idle)
//   rxByte              - shift register contents; holds the received byte once idle
// Parameter SPI_HALF_PERIOD: clk cycles per sclk half-period (1..15).
module nileswan_spi
    import nileswan_pkg::*;
#(
    parameter int unsigned SPI_HALF_PERIOD = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] txByte,
    input  logic       sdi,
    output logic       busy,
    output logic       sclk,
    output logic       sdo,
    output logic [7:0] rxByte
);

    localparam logic [3:0] DIV_LAST = 4'(SPI_HALF_PERIOD - 1);

    spiState_t  state, stateNext;
    logic [3:0] divCnt, divCntNext;
    logic [2:0] bitCnt, bitCntNext;
    logic       sclkNext;
    logic [7:0] shiftReg, shiftRegNext;
    logic       sampled, sampledNext;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= SPI_IDLE;
            divCnt   <= '0;
            bitCnt   <= '0;
            sclk     <= 1'b0;
            shiftReg <= SPI_DATA_RESET;
            sampled  <= 1'b0;
        end else begin
            state    <= stateNext;
            divCnt   <= divCntNext;
            bitCnt   <= bitCntNext;
            sclk     <= sclkNext;
            shiftReg <= shiftRegNext;
            sampled  <= sampledNext;
        end
    end

    // One shift register serves both directions: MOSI leaves from bit 7 while
    // the bit captured on the rising edge enters at bit 0 on the falling edge,
    // so after the eighth fall it holds exactly the received byte.
    always_comb begin
        stateNext    = state;
        divCntNext   = divCnt;
        bitCntNext   = bitCnt;
        sclkNext     = sclk;
        shiftRegNext = shiftReg;
        sampledNext  = sampled;
        case (state)
            SPI_IDLE: begin
                if (start) begin
                    stateNext    = SPI_XFER;
                    shiftRegNext = txByte;
                    divCntNext   = '0;
                    bitCntNext   = '0;
                    sclkNext     = 1'b0;
                end
            end
            SPI_XFER: begin
                if (divCnt == DIV_LAST) begin
                    divCntNext = '0;
                    sclkNext   = ~sclk;
                    if (!sclk) begin
                        sampledNext = sdi;
                    end else begin
                        shiftRegNext = {shiftReg[6:0], sampled};
                        bitCntNext   = bitCnt + 3'd1;
                        if (bitCnt == 3'd7) begin
                            stateNext = SPI_IDLE;
                        end
                    end
                end else begin
                    divCntNext = divCnt + 4'd1;
                end
            end
            default: stateNext = SPI_IDLE;
        endcase
    end

    assign busy   = (state == SPI_XFER);
    assign sdo    = busy & shiftReg[7];
    assign rxByte = shiftReg;

endmodule

// File: rtl/nileswan.sv
// nileswan: cartridge mapper top level.
//   SClk, Reset                - bus clock, synchronous active-high reset
//   nSel, nOE, nWE, nIO        - active-low select / read / write / I/O-cycle flag
//   AddrLo[8:0], AddrHi[3:0]   - bus A8..A0 and A19..A16
//   Data[15:0]                 - bidirectional data bus (driven only on I/O port reads)
//   AddrExt, nPSRAMSel,
//   PSRAM_nLB, PSRAM_nUB       - PSRAM bank address, select and byte lanes
//   MBC                        - authentication serial line
//   DebugLEDs                  - status LEDs
//   FastClk / FastClkEnable    - unused oscillator input / enable request (= SPI busy)
//   SPI_Cs, SPI_Clk, SPI_Do,
//   SPI_Di                     - SPI master
// Build option: NILESWAN_DEBUG_LEDS_EN maps port 0xE2 and drives DebugLEDs.
module nileswan
    import nileswan_pkg::*;
#(
    parameter int unsigned SPI_HALF_PERIOD = 1
) (
    input  logic        SClk,
    input  logic        Reset,
    input  logic        nSel,
    input  logic        nOE,
    input  logic        nWE,
    input  logic        nIO,
    input  logic [8:0]  AddrLo,
    input  logic [3:0]  AddrHi,
    inout  wire  [15:0] Data,
    output logic [6:0]  AddrExt,
    output logic        nPSRAMSel,
    output logic        PSRAM_nLB,
    output logic        PSRAM_nUB,
    output logic        MBC,
    output logic [3:0]  DebugLEDs,
    input  logic        FastClk,
    output logic        FastClkEnable,
    output logic        SPI_Cs,
    output logic        SPI_Clk,
    output logic        SPI_Do,
    input  logic        SPI_Di
);

`ifdef NILESWAN_DEBUG_LEDS_EN
    localparam logic LED_MAPPED = 1'b1;
`else
    localparam logic LED_MAPPED = 1'b0;
`endif

    logic [7:0] bankLinear, bankRam, bankRom0, bankRom1, led;
    logic       spiCs;
    logic       nWEPrev;
    logic [4:0] mbcCnt;
    logic       portMapped, portHit, wrStrobe, spiStart, spiBusy;
    logic [7:0] readVal, spiRx;
    logic       unusedInputs;

    assign unusedInputs = ^{FastClk, AddrLo[8], Data[15:8]};

    // I/O port decode and read mux
    always_comb begin
        portMapped = 1'b1;
        readVal    = '0;
        case (AddrLo[7:0])
            PORT_BANK_LINEAR: readVal = bankLinear;
            PORT_BANK_RAM:    readVal = bankRam;
            PORT_BANK_ROM0:   readVal = bankRom0;
            PORT_BANK_ROM1:   readVal = bankRom1;
            PORT_SPI_DATA:    readVal = spiRx;
            PORT_SPI_CTRL:    readVal = {6'b0, spiCs, spiBusy};
            PORT_LED: begin
                portMapped = LED_MAPPED;
                readVal    = led;
            end
            default:          portMapped = 1'b0;
        endcase
    end

    assign portHit  = ~nSel & ~nIO & portMapped;
    assign wrStrobe = portHit & ~nWE & nWEPrev;
    assign spiStart = wrStrobe & (AddrLo[7:0] == PORT_SPI_DATA) & ~spiBusy;
    assign Data     = (portHit & ~nOE) ? {8'h00, readVal} : 'z;

    always_ff @(posedge SClk) begin
        nWEPrev <= nWE;
        if (Reset) begin
            bankLinear <= BANK_RESET;
            bankRam    <= BANK_RESET;
            bankRom0   <= BANK_RESET;
            bankRom1   <= BANK_RESET;
            led        <= LED_RESET;
            spiCs      <= SPI_CTRL_RESET[1];
            mbcCnt     <= '0;
        end else begin
            if (wrStrobe) begin
                case (AddrLo[7:0])
                    PORT_BANK_LINEAR: bankLinear <= Data[7:0];
                    PORT_BANK_RAM:    bankRam    <= Data[7:0];
                    PORT_BANK_ROM0:   bankRom0   <= Data[7:0];
                    PORT_BANK_ROM1:   bankRom1   <= Data[7:0];
                    PORT_SPI_CTRL:    spiCs      <= Data[1];
                    PORT_LED:         led        <= Data[7:0];
                    default: ;
                endcase
            end
            if (!mbcCnt[4]) begin
                mbcCnt <= mbcCnt + 5'd1;
            end
        end
    end

    // mbcCnt saturates at 16; bit 4 set means the key has been sent.
    assign MBC = Reset | mbcCnt[4] | MBC_UNLOCK[mbcCnt[3:0]];

    // PSRAM decode
    assign nPSRAMSel = ~(~nSel & nIO & (AddrHi != 4'd0));
    assign PSRAM_nLB = (AddrHi == 4'd1) &  AddrLo[0];
    assign PSRAM_nUB = (AddrHi == 4'd1) & ~AddrLo[0];

    always_comb begin
        case (AddrHi)
            4'd0:    AddrExt = '0;
            4'd1:    AddrExt = bankRam[6:0];
            4'd2:    AddrExt = bankRom0[6:0];
            4'd3:    AddrExt = bankRom1[6:0];
            default: AddrExt = {bankLinear[2:0], AddrHi};
        endcase
    end

`ifdef NILESWAN_DEBUG_LEDS_EN
    assign DebugLEDs = led[3:0];
`else
    assign DebugLEDs = '0;
`endif

    assign SPI_Cs        = spiCs;
    assign FastClkEnable = spiBusy;

    nileswan_spi #(
        .SPI_HALF_PERIOD(SPI_HALF_PERIOD)
    ) spi (
        .clk    (SClk),
        .reset  (Reset),
        .start  (spiStart),
        .txByte (Data[7:0]),
        .sdi    (SPI_Di),
        .busy   (spiBusy),
        .sclk   (SPI_Clk),
        .sdo    (SPI_Do),
        .rxByte (spiRx)
    );

endmodule

// File: tb/tb_nileswan.sv
// tb_nileswan: directed bench for nileswan with an expected-value queue.
// An undriven Data bus is pulled up, so high-Z reads as 16'hFFFF.
module tb_nileswan;

    logic        SClk = 1'b0;
    logic        Reset, nSel, nOE, nWE, nIO;
    logic [8:0]  AddrLo;
    logic [3:0]  AddrHi;
    wire  [15:0] Data;
    logic [15:0] dataDrv;
    logic        dataOe;
    logic [6:0]  AddrExt;
    logic        nPSRAMSel, PSRAM_nLB, PSRAM_nUB, MBC;
    logic [3:0]  DebugLEDs;
    logic        FastClk, FastClkEnable, SPI_Cs, SPI_Clk, SPI_Do, SPI_Di;
    logic        loopback;

    assign Data   = dataOe ? dataDrv : 'z;
    pullup (Data);
    assign SPI_Di = loopback ? SPI_Do : 1'b0;

    always #5 SClk = ~SClk;

    nileswan #(.SPI_HALF_PERIOD(1)) dut (
        .SClk(SClk), .Reset(Reset), .nSel(nSel), .nOE(nOE), .nWE(nWE), .nIO(nIO),
        .AddrLo(AddrLo), .AddrHi(AddrHi), .Data(Data), .AddrExt(AddrExt),
        .nPSRAMSel(nPSRAMSel), .PSRAM_nLB(PSRAM_nLB), .PSRAM_nUB(PSRAM_nUB),
        .MBC(MBC), .DebugLEDs(DebugLEDs), .FastClk(FastClk),
        .FastClkEnable(FastClkEnable), .SPI_Cs(SPI_Cs), .SPI_Clk(SPI_Clk),
        .SPI_Do(SPI_Do), .SPI_Di(SPI_Di)
    );

    typedef struct {
        string       tag;
        logic [31:0] value;
    } sbEntry_t;

    sbEntry_t sb[$];
    int compared   = 0;
    int mismatched = 0;

    task automatic sbPush(input string tag, input logic [31:0] value);
        sbEntry_t e;
        e.tag   = tag;
        e.value = value;
        sb.push_back(e);
    endtask

    task automatic sbCheck(input logic [31:0] observed);
        sbEntry_t e;
        compared++;
        if (sb.size() == 0) begin
            mismatched++;
            $error("FAIL scoreboardEmpty observed=%h expected=<none>", observed);
        end else begin
            e = sb.pop_front();
            assert (observed === e.value) else begin
                mismatched++;
                $error("FAIL %s observed=%h expected=%h", e.tag, observed, e.value);
            end
        end
    endtask

    task automatic busIdle();
        nSel   = 1'b1;
        nOE    = 1'b1;
        nWE    = 1'b1;
        nIO    = 1'b1;
        dataOe = 1'b0;
    endtask

    task automatic ioWrite(input logic [7:0] addr, input logic [7:0] val);
        @(negedge SClk);
        nSel    = 1'b0;
        nIO     = 1'b0;
        AddrLo  = {1'b0, addr};
        dataDrv = {8'hAB, val};
        dataOe  = 1'b1;
        nWE     = 1'b0;
        @(negedge SClk);
        busIdle();
    endtask

    task automatic readCheck(input string tag, input logic [7:0] addr, input logic [15:0] expVal);
        logic [15:0] d;
        sbPush(tag, 32'(expVal));
        @(negedge SClk);
        nSel   = 1'b0;
        nIO    = 1'b0;
        nOE    = 1'b0;
        AddrLo = {1'b0, addr};
        #1;
        d = Data;
        sbCheck(32'(d));
        @(negedge SClk);
        busIdle();
    endtask

    task automatic memCheck(input string tag, input logic [3:0] hi, input logic lo0,
                            input logic [6:0] expExt, input logic expLb, input logic expUb);
        @(negedge SClk);
        nSel   = 1'b0;
        nIO    = 1'b1;
        nOE    = 1'b0;
        AddrHi = hi;
        AddrLo = {8'h00, lo0};
        sbPush({tag, ".AddrExt"}, 32'(expExt));
        sbPush({tag, ".nPSRAMSel"}, 32'd0);
        sbPush({tag, ".nLB"}, 32'(expLb));
        sbPush({tag, ".nUB"}, 32'(expUb));
        sbPush({tag, ".DataHighZ"}, 32'h0000FFFF);
        #1;
        sbCheck(32'(AddrExt));
        sbCheck(32'(nPSRAMSel));
        sbCheck(32'(PSRAM_nLB));
        sbCheck(32'(PSRAM_nUB));
        sbCheck(32'(Data));
        @(negedge SClk);
        busIdle();
    endtask

    task automatic selCheck(input string tag, input logic sel, input logic io, input logic [3:0] hi);
        @(negedge SClk);
        nSel   = sel;
        nIO    = io;
        AddrHi = hi;
        sbPush(tag, 32'd1);
        #1;
        sbCheck(32'(nPSRAMSel));
        @(negedge SClk);
        busIdle();
    endtask

    // Writes SPI_DATA with nWE held for holdCycles edges, then observes 40 cycles.
    task automatic spiXfer(input logic [7:0] tx, input int holdCycles,
                           output int pulses, output logic [7:0] mosi, output int busyCycles);
        logic prevClk;
        pulses     = 0;
        mosi       = '0;
        busyCycles = 0;
        prevClk    = 1'b0;
        @(negedge SClk);
        nSel    = 1'b0;
        nIO     = 1'b0;
        AddrLo  = {1'b0, 8'hE0};
        dataDrv = {8'h00, tx};
        dataOe  = 1'b1;
        nWE     = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge SClk);
            if (i == holdCycles - 1) busIdle();
            if (FastClkEnable) busyCycles++;
            if (SPI_Clk && !prevClk) begin
                mosi = {mosi[6:0], SPI_Do};
                pulses++;
            end
            prevClk = SPI_Clk;
        end
    endtask

    task automatic waitIdle(input string tag);
        for (int i = 0; i < 60; i++) begin
            @(negedge SClk);
            if (!FastClkEnable) break;
        end
        sbPush(tag, 32'd0);
        sbCheck(32'(FastClkEnable));
    endtask

    initial begin
        logic [15:0] key;
        int          pulses, busyCycles;
        logic [7:0]  mosi;

        key      = 16'h4A35;
        FastClk  = 1'b0;
        loopback = 1'b1;
        AddrHi   = '0;
        AddrLo   = '0;
        dataDrv  = '0;
        busIdle();
        Reset = 1'b1;
        repeat (3) @(negedge SClk);
        #1;
        sbPush("rst.SPI_Clk", 32'd0);       sbCheck(32'(SPI_Clk));
        sbPush("rst.SPI_Do", 32'd0);        sbCheck(32'(SPI_Do));
        sbPush("rst.MBC", 32'd1);           sbCheck(32'(MBC));
        sbPush("rst.FastClkEnable", 32'd0); sbCheck(32'(FastClkEnable));
        sbPush("rst.SPI_Cs", 32'd1);        sbCheck(32'(SPI_Cs));
        sbPush("rst.DebugLEDs", 32'd0);     sbCheck(32'(DebugLEDs));
        Reset = 1'b0;

        // authentication word, LSB first, one bit per cycle, then idle high
        for (int i = 0; i < 16; i++) begin
            #1;
            sbPush($sformatf("mbcBit%0d", i), 32'(key[i]));
            sbCheck(32'(MBC));
            @(negedge SClk);
        end
        #1;
        sbPush("mbcHold", 32'd1);
        sbCheck(32'(MBC));

        memCheck("memResetF", 4'hF, 1'b0, 7'h7F, 1'b0, 1'b0);
        ioWrite(8'hC0, 8'h02);
        memCheck("memLinear5", 4'h5, 1'b0, 7'h25, 1'b0, 1'b0);
        memCheck("memRom0", 4'h2, 1'b0, 7'h7F, 1'b0, 1'b0);
        memCheck("memRamOdd", 4'h1, 1'b1, 7'h7F, 1'b1, 1'b0);
        ioWrite(8'hC1, 8'h33);
        memCheck("memRamEven", 4'h1, 1'b0, 7'h33, 1'b0, 1'b1);
        ioWrite(8'hC3, 8'h81);
        memCheck("memRom1", 4'h3, 1'b0, 7'h01, 1'b0, 1'b0);
        selCheck("selDeselected", 1'b1, 1'b1, 4'h5);
        selCheck("selIoCycle", 1'b0, 1'b0, 4'h5);
        selCheck("selAddrHi0", 1'b0, 1'b1, 4'h0);
        readCheck("rdBankLinear", 8'hC0, 16'h0002);
        readCheck("rdBankRom0", 8'hC2, 16'h00FF);
        readCheck("rdUnmapped", 8'hC5, 16'hFFFF);

        // nWE held low three edges with data changing: only the first value lands
        @(negedge SClk);
        nSel    = 1'b0;
        nIO     = 1'b0;
        AddrLo  = {1'b0, 8'hC0};
        dataDrv = 16'h0011;
        dataOe  = 1'b1;
        nWE     = 1'b0;
        @(negedge SClk);
        dataDrv = 16'h0022;
        @(negedge SClk);
        @(negedge SClk);
        busIdle();
        memCheck("memHeldWrite", 4'h4, 1'b0, 7'h14, 1'b0, 1'b0);

        ioWrite(8'hE1, 8'hFC);
        #1;
        sbPush("csLow", 32'd0);
        sbCheck(32'(SPI_Cs));
        readCheck("rdCtrlIdle", 8'hE1, 16'h0000);

        spiXfer(8'hA5, 1, pulses, mosi, busyCycles);
        sbPush("xferA5.pulses", 32'd8);   sbCheck(32'(pulses));
        sbPush("xferA5.mosi", 32'hA5);    sbCheck(32'(mosi));
        sbPush("xferA5.busy", 32'd16);    sbCheck(32'(busyCycles));
        sbPush("xferA5.clkIdle", 32'd0);  sbCheck(32'(SPI_Clk));
        readCheck("rdSpiA5", 8'hE0, 16'h00A5);

        spiXfer(8'h3C, 3, pulses, mosi, busyCycles);
        sbPush("xferHeld.pulses", 32'd8); sbCheck(32'(pulses));
        sbPush("xferHeld.mosi", 32'h3C);  sbCheck(32'(mosi));
        sbPush("xferHeld.busy", 32'd16);  sbCheck(32'(busyCycles));
        readCheck("rdSpi3C", 8'hE0, 16'h003C);

        // writes during a transfer: data ignored, CS still updates
        ioWrite(8'hE0, 8'h5A);
        readCheck("rdCtrlBusy", 8'hE1, 16'h0001);
        ioWrite(8'hE0, 8'hFF);
        ioWrite(8'hE1, 8'h02);
        #1;
        sbPush("csWhileBusy", 32'd1);
        sbCheck(32'(SPI_Cs));
        waitIdle("busyWait5A");
        readCheck("rdSpi5A", 8'hE0, 16'h005A);
        readCheck("rdCtrlCsHigh", 8'hE1, 16'h0002);

        ioWrite(8'hE2, 8'h09);
        #1;
`ifdef NILESWAN_DEBUG_LEDS_EN
        sbPush("ledsOut", 32'h9);
        sbCheck(32'(DebugLEDs));
        readCheck("rdLed", 8'hE2, 16'h0009);
`else
        sbPush("ledsOut", 32'h0);
        sbCheck(32'(DebugLEDs));
        readCheck("rdLedUnmapped", 8'hE2, 16'hFFFF);
`endif

        // reset during a transfer aborts it and clears received data
        ioWrite(8'hE0, 8'hFF);
        repeat (4) @(negedge SClk);
        #1;
        sbPush("abort.busyBefore", 32'd1);
        sbCheck(32'(FastClkEnable));
        @(negedge SClk);
        Reset = 1'b1;
        @(negedge SClk);
        #1;
        sbPush("abort.SPI_Clk", 32'd0);       sbCheck(32'(SPI_Clk));
        sbPush("abort.FastClkEnable", 32'd0); sbCheck(32'(FastClkEnable));
        sbPush("abort.SPI_Do", 32'd0);        sbCheck(32'(SPI_Do));
        sbPush("abort.MBC", 32'd1);           sbCheck(32'(MBC));
        Reset = 1'b0;
        readCheck("rdSpiAfterAbort", 8'hE0, 16'h0000);
        readCheck("rdCtrlAfterAbort", 8'hE1, 16'h0002);
        memCheck("memAfterAbort", 4'hF, 1'b0, 7'h7F, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
